fb_scan_reader: RTL and testbench

- Scan-out stage between the dual-port frame buffer (read port B) and the 100 MHz write side of the 24-bit display FIFO. The FIFO is drained at 25 MHz by the VGA logic.
- Reads the 320x240 frame buffer in raster order and upscales it 2x in both directions. Each source pixel is emitted twice horizontally, and each source line is emitted twice vertically, giving a 640x480 pixel stream.
- Absorbs the BRAM read latency under FIFO backpressure without losing or duplicating pixels. Supports mid-frame resynchronisation.

---
 rtl/fb_scan_reader.sv | 201 ++++++++++++++++++++
 tb/tb_fb_scan_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_reader.sv
// Frame buffer scan-out: raster reads with 2x/2x upscale into the display FIFO,
// absorbing BRAM read latency behind a small skid buffer under FIFO backpressure.
module fb_scan_reader #(
    parameter int unsigned H_SRC      = 320,
    parameter int unsigned V_SRC      = 240,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned SKID_DEPTH = RD_LAT + 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        resync_i,
    output logic [16:0] fb_addr_o,
    output logic        fb_re_o,
    input  logic [23:0] fb_dout_i,
    input  logic        fifo_full_i,
    output logic        fifo_wr_en_o,
    output logic [23:0] fifo_din_o,
    output logic        frame_done_o,
    output logic        busy_o
);

    localparam int unsigned H_OUT = 2 * H_SRC;
    localparam int unsigned V_OUT = 2 * V_SRC;
    localparam int unsigned XW    = $clog2(H_OUT);
    localparam int unsigned YW    = $clog2(V_OUT);
    localparam int unsigned CW    = $clog2(SKID_DEPTH + RD_LAT + 1);
    localparam int unsigned PW    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XW-1:0] out_x_q, out_x_d;
    logic [YW-1:0] out_y_q, out_y_d;
    logic [16:0]   line_base_q, line_base_d;

    logic [RD_LAT-1:0] tag_q, tag_d;
    logic [RD_LAT-1:0] eof_q, eof_d;

    logic [23:0]           buf_data_q [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] buf_eof_q;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [CW-1:0] in_flight;
    logic [CW-1:0] credit;
    logic          run_live;
    logic          ret_vld;
    logic          ret_eof;
    logic          issue;
    logic          push;
    logic          pop;
    logic          last_px;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + CW'(tag_q[i]);
        end
        run_live = (state_q == RUN) && !resync_i;
        ret_vld  = tag_q[RD_LAT-1];
        ret_eof  = eof_q[RD_LAT-1];
        pop      = run_live && (count_q != '0) && !fifo_full_i;
        push     = run_live && ret_vld;
        // The entry leaving this cycle frees its slot, so steady state sustains one read per cycle.
        credit   = in_flight + count_q - CW'(pop);
        issue    = run_live && en_i && (credit < CW'(SKID_DEPTH));
        last_px  = (out_x_q == XW'(H_OUT - 1)) && (out_y_q == YW'(V_OUT - 1));
    end

    always_comb begin
        tag_d    = '0;
        eof_d    = '0;
        tag_d[0] = issue;
        eof_d[0] = issue && last_px;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
            eof_d[i] = eof_q[i-1];
        end
    end

    always_comb begin
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        line_base_d = line_base_q;
        if (resync_i) begin
            out_x_d     = '0;
            out_y_d     = '0;
            line_base_d = '0;
        end else if (issue) begin
            if (out_x_q == XW'(H_OUT - 1)) begin
                out_x_d = '0;
                if (out_y_q == YW'(V_OUT - 1)) begin
                    out_y_d     = '0;
                    line_base_d = '0;
                end else begin
                    out_y_d = out_y_q + 1'b1;
                    // Odd output line closes a source-line pair.
                    if (out_y_q[0]) begin
                        line_base_d = line_base_q + 17'(H_SRC);
                    end
                end
            end else begin
                out_x_d = out_x_q + 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (resync_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (resync_i) begin
                    state_d = FLUSH;
                end else if (!en_i && (in_flight == '0) && (count_q == '0)) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (!resync_i && (in_flight == '0)) begin
                    state_d = en_i ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            out_x_q     <= '0;
            out_y_q     <= '0;
            line_base_q <= '0;
            tag_q       <= '0;
            eof_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            buf_eof_q   <= '0;
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            line_base_q <= line_base_d;
            tag_q       <= tag_d;
            eof_q       <= eof_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            if (push) begin
                buf_data_q[wr_ptr_q] <= fb_dout_i;
                buf_eof_q[wr_ptr_q]  <= ret_eof;
            end
        end
    end

    assign fb_addr_o    = line_base_q + 17'(out_x_q[XW-1:1]);
    assign fb_re_o      = issue;
    assign fifo_wr_en_o = pop;
    assign fifo_din_o   = buf_data_q[rd_ptr_q];
    assign frame_done_o = pop && buf_eof_q[rd_ptr_q];
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: RD_LAT=1 and RD_LAT=2 instances on a reduced 8x4 source
// frame share stimulus; each output stream is scored against the raster/upscale formula.
module tb_fb_scan_reader;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int W  = 2 * H;
    localparam int FR = 4 * H * V;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic        resync;
    logic        full;
    logic [16:0] fb_addr [2];
    logic        fb_re   [2];
    logic [23:0] fb_dout [2];
    logic        wr_en   [2];
    logic [23:0] din     [2];
    logic        fd      [2];
    logic        busy    [2];
    logic [16:0] fbd1;

    fb_scan_reader #(.H_SRC(H), .V_SRC(V), .RD_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .resync_i(resync),
        .fb_addr_o(fb_addr[0]), .fb_re_o(fb_re[0]), .fb_dout_i(fb_dout[0]),
        .fifo_full_i(full), .fifo_wr_en_o(wr_en[0]), .fifo_din_o(din[0]),
        .frame_done_o(fd[0]), .busy_o(busy[0])
    );

    fb_scan_reader #(.H_SRC(H), .V_SRC(V), .RD_LAT(2)) u_lat2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .resync_i(resync),
        .fb_addr_o(fb_addr[1]), .fb_re_o(fb_re[1]), .fb_dout_i(fb_dout[1]),
        .fifo_full_i(full), .fifo_wr_en_o(wr_en[1]), .fifo_din_o(din[1]),
        .frame_done_o(fd[1]), .busy_o(busy[1])
    );

    // Frame buffer models: data word equals the address, 1 and 2 cycle latency.
    always @(posedge clk) begin
        fb_dout[0] <= {7'd0, fb_addr[0]};
        fbd1       <= fb_addr[1];
        fb_dout[1] <= {7'd0, fbd1};
    end

    typedef struct {
        int n;
        int addr;
        bit done;
    } vec_t;

    vec_t        vecs [16];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n      [2];
    int          outst  [2];
    logic [23:0] logd   [2][256];
    logic        logfd  [2][256];
    int          logcyc [2][256];

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_addr(input int idx);
        int m;
        m = idx % FR;
        return ((m / W) / 2) * H + (m % W) / 2;
    endfunction

    task automatic mon();
        int e;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                n[k]     = 0;
                outst[k] = 0;
            end else begin
                if (full) chk(!wr_en[k], $sformatf("wr_while_full[%0d]", k), int'(wr_en[k]), 0);
                if (fd[k]) chk(wr_en[k], $sformatf("done_without_wr[%0d]", k), int'(wr_en[k]), 1);
                if (!busy[k]) chk(outst[k] == 0 && !wr_en[k], $sformatf("idle_undrained[%0d]", k), outst[k], 0);
                if (wr_en[k]) begin
                    e = exp_addr(n[k]);
                    chk(int'(din[k]) == e, $sformatf("stream[%0d] n=%0d", k, n[k]), int'(din[k]), e);
                    chk(fd[k] == ((n[k] % FR) == FR - 1), $sformatf("frame_done[%0d] n=%0d", k, n[k]),
                        int'(fd[k]), int'((n[k] % FR) == FR - 1));
                    if (n[k] < 256) begin
                        logd[k][n[k]]   = din[k];
                        logfd[k][n[k]]  = fd[k];
                        logcyc[k][n[k]] = cyc;
                    end
                    n[k]++;
                    outst[k]--;
                end
                if (fb_re[k]) outst[k]++;
                chk(outst[k] <= k + 2, $sformatf("skid_bound[%0d]", k), outst[k], k + 2);
                if (resync) begin
                    n[k]     = 0;
                    outst[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_n(input int target, input int budget, input bit only0);
        int b;
        b = 0;
        while ((n[0] < target || (!only0 && n[1] < target)) && b < budget) begin
            tick();
            b++;
        end
        if (n[0] < target || (!only0 && n[1] < target)) chk(1'b0, "timeout", n[0], target);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk(fb_addr[k] == '0, $sformatf("%s fb_addr[%0d]", tag, k), int'(fb_addr[k]), 0);
            chk(!fb_re[k], $sformatf("%s fb_re[%0d]", tag, k), int'(fb_re[k]), 0);
            chk(!wr_en[k], $sformatf("%s wr_en[%0d]", tag, k), int'(wr_en[k]), 0);
            chk(din[k] == '0, $sformatf("%s din[%0d]", tag, k), int'(din[k]), 0);
            chk(!fd[k], $sformatf("%s frame_done[%0d]", tag, k), int'(fd[k]), 0);
            chk(!busy[k], $sformatf("%s busy[%0d]", tag, k), int'(busy[k]), 0);
        end
    endtask

    initial begin
        int  e0, r0, s0, l0;
        bit  gap;

        vecs[0]  = '{0, 0, 0};    vecs[1]  = '{1, 0, 0};
        vecs[2]  = '{2, 1, 0};    vecs[3]  = '{3, 1, 0};
        vecs[4]  = '{15, 7, 0};   vecs[5]  = '{16, 0, 0};
        vecs[6]  = '{31, 7, 0};   vecs[7]  = '{32, 8, 0};
        vecs[8]  = '{33, 8, 0};   vecs[9]  = '{64, 16, 0};
        vecs[10] = '{100, 26, 0}; vecs[11] = '{126, 31, 0};
        vecs[12] = '{127, 31, 1}; vecs[13] = '{128, 0, 0};
        vecs[14] = '{129, 0, 0};  vecs[15] = '{139, 5, 0};

        rst_n = 1'b0; en = 1'b0; resync = 1'b0; full = 1'b0;
        n[0] = 0; n[1] = 0; outst[0] = 0; outst[1] = 0;
        repeat (3) tick();
        chk_zero("reset");

        // Unstalled stream across a frame wrap.
        rst_n = 1'b1; en = 1'b1; e0 = cyc;
        wait_n(140, 600, 1'b0);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 2; k++) begin
                chk(int'(logd[k][vecs[i].n]) == vecs[i].addr, $sformatf("vec[%0d] addr n=%0d", k, vecs[i].n),
                    int'(logd[k][vecs[i].n]), vecs[i].addr);
                chk(logfd[k][vecs[i].n] == vecs[i].done, $sformatf("vec[%0d] done n=%0d", k, vecs[i].n),
                    int'(logfd[k][vecs[i].n]), int'(vecs[i].done));
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk(logcyc[k][0] == e0 + 3 + k, $sformatf("startup_latency[%0d]", k), logcyc[k][0] - e0, 3 + k);
            gap = 1'b0;
            for (int i = 0; i < 139; i++) if (logcyc[k][i+1] != logcyc[k][i] + 1) gap = 1'b1;
            chk(!gap, $sformatf("throughput[%0d]", k), int'(gap), 0);
        end

        // Resync mid-line with reads in flight.
        resync = 1'b1; r0 = cyc;
        tick();
        resync = 1'b0;
        wait_n(100, 400, 1'b1);
        for (int k = 0; k < 2; k++)
            chk(logcyc[k][0] == r0 + 2 * (k + 1) + 2, $sformatf("resync_first_wr[%0d]", k),
                logcyc[k][0] - r0, 2 * (k + 1) + 2);

        // Backpressure from output pixel 100.
        full = 1'b1; s0 = cyc;
        repeat (10) tick();
        full = 1'b0;
        wait_n(110, 400, 1'b0);
        chk(logcyc[0][99] == s0 - 1 && logcyc[0][100] == s0 + 10, "stall_gap",
            logcyc[0][100] - logcyc[0][99], 11);
        chk(int'(logd[0][100]) == 26, "stall_resume[0]", int'(logd[0][100]), 26);
        chk(int'(logd[1][100]) == 26, "stall_resume[1]", int'(logd[1][100]), 26);

        // Back-to-back resync: the second lands in FLUSH and restarts it.
        resync = 1'b1; r0 = cyc;
        tick();
        tick();
        resync = 1'b0;
        wait_n(40, 400, 1'b0);
        chk(logcyc[0][0] == r0 + 5, "double_resync[0]", logcyc[0][0] - r0, 5);
        chk(logcyc[1][0] == r0 + 6, "double_resync[1]", logcyc[1][0] - r0, 6);

        // en low for 5 cycles at a random point; stream must stay contiguous.
        repeat ($urandom_range(3, 20)) tick();
        en = 1'b0; l0 = n[0];
        tick();
        for (int k = 0; k < 2; k++) chk(busy[k], $sformatf("busy_while_draining[%0d]", k), int'(busy[k]), 1);
        repeat (3) tick();
        for (int k = 0; k < 2; k++) chk(!busy[k], $sformatf("busy_after_drain[%0d]", k), int'(busy[k]), 0);
        tick();
        en = 1'b1;
        wait_n(l0 + 60, 400, 1'b0);

        // Resync while idle only clears the position.
        en = 1'b0;
        repeat (6) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0; en = 1'b1; e0 = cyc;
        wait_n(5, 100, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk(int'(logd[k][0]) == 0 && int'(logd[k][2]) == 1, $sformatf("idle_resync_data[%0d]", k),
                int'(logd[k][2]), 1);
            chk(logcyc[k][0] == e0 + 3 + k, $sformatf("idle_resync_latency[%0d]", k), logcyc[k][0] - e0, 3 + k);
        end

        // Asynchronous reset mid-stream.
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        tick();
        tick();
        rst_n = 1'b1; e0 = cyc;
        wait_n(5, 100, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk(int'(logd[k][0]) == 0, $sformatf("post_reset_data[%0d]", k), int'(logd[k][0]), 0);
            chk(logcyc[k][0] == e0 + 3 + k, $sformatf("post_reset_latency[%0d]", k), logcyc[k][0] - e0, 3 + k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
